// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I-subset controller: state codes,
// opcodes, ALU operation classes and ALU control codes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, selects,
// strobes and status out. The controller side is the master.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] imm_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       adr_src;
  logic [2:0] alu_control;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    input  op, funct3, funct7b5, zero,
    output imm_src, alu_src_a, alu_src_b, result_src, adr_src, alu_control,
           ir_write, pc_write, reg_write, mem_write, instr_done, illegal, state_o
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  imm_src, alu_src_a, alu_src_b, result_src, adr_src, alu_control,
           ir_write, pc_write, reg_write, mem_write, instr_done, illegal, state_o
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALU operation class plus the
// instruction function fields onto the 3-bit ALU control code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  // ALU control selection by operation class and funct3
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 only selects sub for R-type; I-type addi keeps it as an immediate bit
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I-subset core: state register,
// next-state logic, per-state output table and immediate-format decoder.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.master ctrl
);

  state_t     state_r;
  state_t     state_next_s;
  state_t     cur_s;
  logic [1:0] alu_op_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] result_src_s;
  logic [1:0] imm_src_s;
  logic [2:0] alu_control_s;
  logic       adr_src_s;
  logic       pc_update_s;
  logic       branch_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic       mem_write_s;
  logic       instr_done_s;
  logic       illegal_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_FETCH: state_next_s = S_DECODE;
      S_DECODE: begin
        case (ctrl.op)
          OP_LW, OP_SW: state_next_s = S_MEMADR;
          OP_R:         state_next_s = S_EXECUTER;
          OP_I:         state_next_s = S_EXECUTEI;
          OP_BEQ:       state_next_s = S_BEQ;
          OP_JAL:       state_next_s = S_JAL;
          default:      state_next_s = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (ctrl.op == OP_LW) begin
          state_next_s = S_MEMREAD;
        end else begin
          state_next_s = S_MEMWRITE;
        end
      end
      S_MEMREAD:  state_next_s = S_MEMWB;
      S_MEMWB:    state_next_s = S_FETCH;
      S_MEMWRITE: state_next_s = S_FETCH;
      S_EXECUTER: state_next_s = S_ALUWB;
      S_EXECUTEI: state_next_s = S_ALUWB;
      S_JAL:      state_next_s = S_ALUWB;
      S_ALUWB:    state_next_s = S_FETCH;
      S_BEQ:      state_next_s = S_FETCH;
      S_TRAP:     state_next_s = S_TRAP;
      default:    state_next_s = S_FETCH;
    endcase
  end

  // Per-state output table; reset presents FETCH selects with every strobe suppressed
  always_comb begin
    cur_s        = reset ? S_FETCH : state_r;
    alu_op_s     = ALUOP_ADD;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    result_src_s = 2'b00;
    adr_src_s    = 1'b0;
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    mem_write_s  = 1'b0;
    instr_done_s = 1'b0;
    illegal_s    = 1'b0;
    case (cur_s)
      S_FETCH: begin
        ir_write_s   = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        pc_update_s  = 1'b1;
      end
      S_DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
      end
      S_MEMREAD: adr_src_s = 1'b1;
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_s    = 1'b1;
        mem_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      S_BEQ: begin
        alu_src_a_s  = 2'b10;
        alu_op_s     = ALUOP_SUB;
        branch_s     = 1'b1;
        instr_done_s = 1'b1;
      end
      S_JAL: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_update_s = 1'b1;
      end
      S_TRAP:  illegal_s = 1'b1;
      default: illegal_s = 1'b0;
    endcase
    if (reset) begin
      ir_write_s   = 1'b0;
      pc_update_s  = 1'b0;
      branch_s     = 1'b0;
      reg_write_s  = 1'b0;
      mem_write_s  = 1'b0;
      instr_done_s = 1'b0;
      illegal_s    = 1'b0;
    end else begin
      illegal_s = illegal_s;
    end
  end

  // Immediate format from opcode
  always_comb begin
    imm_src_s = IMM_I;
    case (ctrl.op)
      OP_LW, OP_I: imm_src_s = IMM_I;
      OP_SW:       imm_src_s = IMM_S;
      OP_BEQ:      imm_src_s = IMM_B;
      OP_JAL:      imm_src_s = IMM_J;
      default:     imm_src_s = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op_s),
    .funct3      (ctrl.funct3),
    .funct7b5    (ctrl.funct7b5),
    .op5         (ctrl.op[5]),
    .alu_control (alu_control_s)
  );

  assign ctrl.imm_src     = imm_src_s;
  assign ctrl.alu_src_a   = alu_src_a_s;
  assign ctrl.alu_src_b   = alu_src_b_s;
  assign ctrl.result_src  = result_src_s;
  assign ctrl.adr_src     = adr_src_s;
  assign ctrl.alu_control = alu_control_s;
  assign ctrl.ir_write    = ir_write_s;
  assign ctrl.pc_write    = pc_update_s | (branch_s & ctrl.zero);
  assign ctrl.reg_write   = reg_write_s;
  assign ctrl.mem_write   = mem_write_s;
  assign ctrl.instr_done  = instr_done_s;
  assign ctrl.illegal     = illegal_s;
  assign ctrl.state_o     = cur_s;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one trapping and one non-trapping
// instance, hand-computed state sequences, strobe counts and decode values.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic reset2;
  int   n_vec = 0;
  int   n_err = 0;

  logic [3:0] exp_seq [0:4];
  logic [1:0] e_imm;
  logic [2:0] e_alu;
  int         e_rw, e_mw, e_pcw;

  multicycle_controller_if b1 ();
  multicycle_controller_if b2 ();

  multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1)) dut1 (.clk(clk), .reset(reset),  .ctrl(b1.master));
  multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut2 (.clk(clk), .reset(reset2), .ctrl(b2.master));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH through the expected state list
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z, input int len);
    int s_rw, s_mw, s_pcw, s_done;
    s_rw = 0; s_mw = 0; s_pcw = 0; s_done = 0;
    b1.op = op; b1.funct3 = f3; b1.funct7b5 = f7; b1.zero = z;
    #1;
    for (int i = 0; i < len; i++) begin
      chk({name, "_state"}, 32'(b1.state_o), 32'(exp_seq[i]));
      s_rw   += int'(b1.reg_write);
      s_mw   += int'(b1.mem_write);
      s_pcw  += int'(b1.pc_write);
      s_done += int'(b1.instr_done);
      if (exp_seq[i] == 4'd1) chk({name, "_imm"}, 32'(b1.imm_src), 32'(e_imm));
      if (exp_seq[i] == 4'd4) chk({name, "_wbsrc"}, 32'(b1.result_src), 32'h1);
      if (exp_seq[i] == 4'd5) chk({name, "_adr"}, 32'(b1.adr_src), 32'h1);
      if (exp_seq[i] == 4'd6 || exp_seq[i] == 4'd7)
        chk({name, "_alu"}, 32'(b1.alu_control), 32'(e_alu));
      if (exp_seq[i] == 4'd9) begin
        chk({name, "_alu"}, 32'(b1.alu_control), 32'h1);
        chk({name, "_brpc"}, 32'(b1.pc_write), 32'(z));
      end
      step();
    end
    chk({name, "_end"}, 32'(b1.state_o), 32'h0);
    chk({name, "_done"}, 32'(s_done), 32'd1);
    chk({name, "_rw"}, 32'(s_rw), 32'(e_rw));
    chk({name, "_mw"}, 32'(s_mw), 32'(e_mw));
    chk({name, "_pcw"}, 32'(s_pcw), 32'(e_pcw));
  endtask

  initial begin
    int s_strobe;
    reset = 1'b1; reset2 = 1'b1;
    b1.op = OP_LW; b1.funct3 = 3'b000; b1.funct7b5 = 1'b0; b1.zero = 1'b1;
    b2.op = 7'b1111111; b2.funct3 = 3'b000; b2.funct7b5 = 1'b0; b2.zero = 1'b1;
    step(); step();
    chk("rst_state", 32'(b1.state_o), 32'h0);
    chk("rst_strobes", 32'({b1.ir_write, b1.pc_write, b1.reg_write, b1.mem_write, b1.instr_done, b1.illegal}), 32'h0);

    // Abort an lw in MEMREAD with a 3-cycle reset
    reset = 1'b0;
    #1;
    chk("fetch_irw", 32'(b1.ir_write), 32'h1);
    step(); step(); step();
    chk("pre_abort_state", 32'(b1.state_o), 32'h3);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("abort_state", 32'(b1.state_o), 32'h0);
      chk("abort_strobes", 32'({b1.ir_write, b1.pc_write, b1.reg_write, b1.mem_write, b1.instr_done, b1.illegal}), 32'h0);
      chk("abort_srcb", 32'(b1.alu_src_b), 32'h2);
      step();
    end
    reset = 1'b0;
    #1;
    chk("recover_state", 32'(b1.state_o), 32'h0);
    chk("recover_irw_pcw", 32'({b1.ir_write, b1.pc_write}), 32'h3);

    exp_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    e_imm = 2'b00; e_alu = 3'b000; e_rw = 1; e_mw = 0; e_pcw = 1;
    run_instr("lw", OP_LW, 3'b010, 1'b0, 1'b1, 5);

    exp_seq = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    e_imm = 2'b01; e_rw = 0; e_mw = 1; e_pcw = 1;
    run_instr("sw", OP_SW, 3'b010, 1'b0, 1'b1, 4);

    exp_seq = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd0};
    e_imm = 2'b10; e_rw = 0; e_mw = 0; e_pcw = 2;
    run_instr("beq_taken", OP_BEQ, 3'b000, 1'b0, 1'b1, 3);
    e_pcw = 1;
    run_instr("beq_nt", OP_BEQ, 3'b000, 1'b0, 1'b0, 3);

    exp_seq = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
    e_imm = 2'b00; e_alu = 3'b001; e_rw = 1; e_mw = 0; e_pcw = 1;
    run_instr("r_sub", OP_R, 3'b000, 1'b1, 1'b1, 4);
    e_alu = 3'b011;
    run_instr("r_or", OP_R, 3'b110, 1'b0, 1'b1, 4);

    exp_seq = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
    e_alu = 3'b000;
    run_instr("i_add", OP_I, 3'b000, 1'b1, 1'b1, 4);
    e_alu = 3'b010;
    run_instr("i_and", OP_I, 3'b111, 1'b0, 1'b1, 4);
    e_alu = 3'b101;
    run_instr("i_slt", OP_I, 3'b010, 1'b0, 1'b1, 4);

    exp_seq = '{4'd0, 4'd1, 4'd10, 4'd8, 4'd0};
    e_imm = 2'b11; e_rw = 1; e_pcw = 2;
    run_instr("jal", OP_JAL, 3'b000, 1'b0, 1'b1, 4);

    // Illegal opcode on the trapping instance
    b1.op = 7'b1111111;
    #1;
    chk("ill_fetch", 32'(b1.state_o), 32'h0);
    step();
    chk("ill_decode", 32'(b1.state_o), 32'h1);
    step();
    s_strobe = 0;
    for (int i = 0; i < 20; i++) begin
      chk("trap_ill", 32'({b1.state_o, b1.illegal}), 32'h1F);
      s_strobe += int'(b1.ir_write) + int'(b1.pc_write) + int'(b1.reg_write)
                + int'(b1.mem_write) + int'(b1.instr_done);
      step();
    end
    chk("trap_strobes", 32'(s_strobe), 32'h0);
    reset = 1'b1;
    #1;
    chk("trap_rst_ill", 32'(b1.illegal), 32'h0);
    step();
    reset = 1'b0;
    #1;
    chk("trap_recover", 32'({b1.state_o, b1.ir_write}), 32'h1);

    // Illegal opcode on the non-trapping instance falls back to FETCH
    reset2 = 1'b0;
    #1;
    chk("nt_fetch", 32'(b2.state_o), 32'h0);
    step();
    chk("nt_decode", 32'({b2.state_o, b2.instr_done, b2.illegal}), 32'h4);
    step();
    chk("nt_back", 32'({b2.state_o, b2.illegal, b2.ir_write}), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
